// File: rtl/opl3_wrbuf_pkg.sv
// Shared types for the OPL3 write-pacing buffer: FIFO entry, replay states and
// the pacing counter width.
package opl3_wrbuf_pkg;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } replay_state_t;

  // Recovery gap load value: data-port writes need the long gap.
  function automatic logic [CNT_W-1:0] gap_load(input logic a0,
                                                input int unsigned gap_addr,
                                                input int unsigned gap_data);
    return a0 ? CNT_W'(gap_data - 1) : CNT_W'(gap_addr - 1);
  endfunction

endpackage

// File: rtl/opl3_wrbuf_fifo.sv
// Single-clock show-ahead FIFO of wr_entry_t; push ignored when full, pop
// ignored when empty.
module opl3_wrbuf_fifo
  import opl3_wrbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wr_entry_t                din,
  output wr_entry_t                dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wr_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opl3_wrbuf.sv
// OPL3 write-pacing buffer: queues CPU register writes and replays them as
// paced we pulses. Optional CPU wait/pending-entry mode: OPL3_WRBUF_WAIT_EN.
module opl3_wrbuf
  import opl3_wrbuf_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WE_HIGH  = 4,
  parameter int unsigned GAP_ADDR = 12,
  parameter int unsigned GAP_DATA = 84
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_we,
  output logic [7:0] cpu_dout,
  input  logic [7:0] opl_dout,
  output logic [1:0] opl_addr,
  output logic [7:0] opl_din,
  output logic       opl_we,
  output logic       empty,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       wait_n
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              cpu_we_q;
  logic              rise_c;
  wr_entry_t         req_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  wr_entry_t         push_data_c;
  wr_entry_t         head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  replay_state_t     state_q;
  replay_state_t     state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              we_d;
  logic [1:0]        addr_d;
  logic [7:0]        din_d;

  assign cpu_dout = opl_dout;
  assign rise_c   = cpu_we && !cpu_we_q;
  assign req_c    = '{addr: cpu_addr, data: cpu_din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_we_q <= 1'b0;
    end else begin
      cpu_we_q <= cpu_we;
    end
  end

`ifdef OPL3_WRBUF_WAIT_EN
  logic      pend_valid;
  wr_entry_t pend_entry;

  // A held entry always goes first; new edges while holding are ignored.
  always_comb begin
    push_c      = 1'b0;
    push_data_c = req_c;
    drop_c      = 1'b0;
    if (pend_valid) begin
      push_c      = !fifo_full;
      push_data_c = pend_entry;
    end else if (rise_c && !fifo_full) begin
      push_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_entry <= '0;
    end else if (pend_valid) begin
      if (!fifo_full) begin
        pend_valid <= 1'b0;
      end
    end else if (rise_c && fifo_full) begin
      pend_valid <= 1'b1;
      pend_entry <= req_c;
    end
  end

  assign wait_n = ~pend_valid;
`else
  always_comb begin
    push_c      = rise_c && !fifo_full;
    push_data_c = req_c;
    drop_c      = rise_c && fifo_full;
  end

  assign wait_n = 1'b1;
`endif

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  opl3_wrbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (push_data_c),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opl_we   <= 1'b0;
      opl_addr <= 2'd0;
      opl_din  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opl_we   <= we_d;
      opl_addr <= addr_d;
      opl_din  <= din_d;
    end
  end

  // Replay engine: address/data held stable from pop until the gap expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = opl_we;
    addr_d  = opl_addr;
    din_d   = opl_din;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          addr_d  = head.addr;
          din_d   = head.data;
          we_d    = 1'b1;
          cnt_d   = CNT_W'(WE_HIGH - 1);
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          we_d    = 1'b0;
          cnt_d   = gap_load(opl_addr[0], GAP_ADDR, GAP_DATA);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign empty = (fifo_count == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_opl3_wrbuf.sv
// Directed bench for opl3_wrbuf: scoreboarded replay order, pulse/gap timing,
// overflow or wait behaviour (OPL3_WRBUF_WAIT_EN), hold and async reset.
module tb_opl3_wrbuf;

  localparam int WE_HIGH  = 4;
  localparam int GAP_ADDR = 12;
  localparam int GAP_DATA = 84;
  localparam int DEPTH    = 16;
`ifdef OPL3_WRBUF_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       cpu_we;
  logic [7:0] cpu_dout;
  logic [7:0] opl_dout;
  logic [1:0] opl_addr;
  logic [7:0] opl_din;
  logic       opl_we;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;
  logic       wait_n;

  int checks;
  int errors;
  int cyc;
  int pulse_cnt;
  int last_rise;
  int last_fall;
  logic [9:0] want_q[$];

  // monitor state
  logic       m_prev;
  int         m_hi;
  int         m_lo;
  bit         m_first;
  logic       m_a0;
  logic [9:0] m_want;

  opl3_wrbuf #(
    .DEPTH    (DEPTH),
    .WE_HIGH  (WE_HIGH),
    .GAP_ADDR (GAP_ADDR),
    .GAP_DATA (GAP_DATA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .cpu_dout (cpu_dout),
    .opl_dout (opl_dout),
    .opl_addr (opl_addr),
    .opl_din  (opl_din),
    .opl_we   (opl_we),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .wait_n   (wait_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, output int t);
    tick();
    cpu_addr = a;
    cpu_din  = d;
    cpu_we   = 1'b1;
    t        = cyc;
    tick();
    cpu_we   = 1'b0;
  endtask

  task automatic wait_empty(input int maxc, output int t);
    int n;
    n = 0;
    while (!empty && n < maxc) begin
      tick();
      n++;
    end
    if (!empty) check("empty_timeout", 0, 1);
    t = cyc;
  endtask

  // Scoreboard monitor: pops one expected entry per rising opl_we.
  initial begin
    m_prev  = 1'b0;
    m_hi    = 0;
    m_lo    = 0;
    m_first = 1'b1;
    m_a0    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_prev  = 1'b0;
        m_hi    = 0;
        m_lo    = 0;
        m_first = 1'b1;
      end else begin
        if (opl_we && !m_prev) begin
          pulse_cnt++;
          last_rise = cyc;
          if (!m_first)
            check("gap_min", int'(m_lo >= ((m_a0 ? GAP_DATA : GAP_ADDR) + 1)), 1);
          check("pulse_expected", int'(want_q.size() > 0), 1);
          if (want_q.size() > 0) begin
            m_want = want_q.pop_front();
            check("replay_entry", int'({opl_addr, opl_din}), int'(m_want));
          end
          m_hi = 1;
        end else if (opl_we) begin
          m_hi++;
        end else if (m_prev) begin
          check("we_width", m_hi, WE_HIGH);
          last_fall = cyc;
          m_a0      = opl_addr[0];
          m_lo      = 1;
          m_first   = 1'b0;
        end else begin
          m_lo++;
        end
        m_prev = opl_we;
      end
    end
  end

  initial begin
    int t0, t1, te, base, n;
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    last_rise = 0;
    last_fall = 0;
    rst_n     = 1'b0;
    cpu_addr  = 2'd0;
    cpu_din   = 8'd0;
    cpu_we    = 1'b0;
    opl_dout  = 8'h5A;
    ovf_clr   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_opl_we", int'(opl_we), 0);
    check("rst_opl_addr", int'(opl_addr), 0);
    check("rst_opl_din", int'(opl_din), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_wait_n", int'(wait_n), 1);
    check("rst_empty", int'(empty), 1);
    check("cpu_dout_pass", int'(cpu_dout), 8'h5A);
    opl_dout = 8'hC3;
    #1;
    check("cpu_dout_pass2", int'(cpu_dout), 8'hC3);

    // single address write: latency, width and 12-cycle gap
    want_q.push_back({2'd0, 8'h04});
    wr(2'd0, 8'h04, t0);
    check("t1_not_empty", int'(empty), 0);
    wait_empty(100, te);
    check("t1_latency", last_rise - t0, 2);
    check("t1_addr_gap", te - last_fall, GAP_ADDR);

    // address then data write, two cycles apart
    want_q.push_back({2'd0, 8'h20});
    want_q.push_back({2'd1, 8'h01});
    wr(2'd0, 8'h20, t0);
    wr(2'd1, 8'h01, t1);
    check("t2_spacing", t1 - t0, 2);
    wait_empty(300, te);
    check("t2_second_rise", last_rise - t0, 2 + WE_HIGH + GAP_ADDR + 1);
    check("t2_data_gap", te - last_fall, GAP_DATA);

    // 17-write burst behind a busy engine
    base = pulse_cnt;
    want_q.push_back({2'd1, 8'hA0});
    wr(2'd1, 8'hA0, t0);
    for (int i = 0; i < 17; i++) begin
      if (WAIT_EN || i < DEPTH) want_q.push_back({2'd1, 8'(i)});
      wr(2'd1, 8'(i), t1);
    end
    check("burst_overflow", int'(overflow), WAIT_EN ? 0 : 1);
    check("burst_wait_n", int'(wait_n), WAIT_EN ? 0 : 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", int'(overflow), 0);
    wait_empty(3000, te);
    check("burst_pulses", pulse_cnt - base, WAIT_EN ? 18 : 17);
    check("burst_wait_n_end", int'(wait_n), 1);
    check("burst_overflow_end", int'(overflow), 0);

    // cpu_we held high for 50 cycles
    base = pulse_cnt;
    tick();
    cpu_addr = 2'd0;
    cpu_din  = 8'h55;
    cpu_we   = 1'b1;
    want_q.push_back({2'd0, 8'h55});
    repeat (50) tick();
    cpu_we = 1'b0;
    wait_empty(500, te);
    check("hold_one_write", pulse_cnt - base, 1);

    // async reset in the middle of the third of five pulses
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      want_q.push_back({2'd0, 8'(8'h40 + i)});
      wr(2'd0, 8'(8'h40 + i), t1);
    end
    n = 0;
    while (pulse_cnt < base + 3 && n < 500) begin
      tick();
      n++;
    end
    check("rst_third_pulse", pulse_cnt - base, 3);
    tick();
    check("rst_mid_we_high", int'(opl_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_we_drop", int'(opl_we), 0);
    check("rst_empty_now", int'(empty), 1);
    want_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    check("rst_no_more_pulses", pulse_cnt - base, 3);
    check("rst_empty_after", int'(empty), 1);

    check("sb_drained", want_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
